// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the MMIO data bus, with optional short lock bursts.
// Grant takes effect one edge after the request; ack and read data are combinational in the grant cycle.
module mmio_bus_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic [1:0]    grant
);

  localparam int unsigned CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  // Encoding doubles as the one-hot grant vector {m1,m0}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rr_last_q, rr_last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  // rr_last = 1 means m1 was served last, so m0 wins a tie.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || rr_last_q)) begin
          state_d = G0;
        end else if (m1_req) begin
          state_d = G1;
        end
      end
      G0: begin
        if (m0_req && m0_lock && (lock_cnt_q < LOCK_LAST)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          rr_last_d  = 1'b0;
        end
      end
      G1: begin
        if (m1_req && m1_lock && (lock_cnt_q < LOCK_LAST)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          rr_last_d  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    grant     = state_q;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    unique case (state_q)
      G0: begin
        bus_we    = m0_req & m0_we;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        m0_ack    = m0_req;
        m0_rdata  = bus_rdata;
      end
      G1: begin
        bus_we    = m1_req & m1_we;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        m1_ack    = m1_req;
        m1_rdata  = bus_rdata;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed and randomized checks of mmio_bus_arbiter: reset, single request, tie, lock bursts.
module tb_mmio_bus_arbiter;

  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 32;
  localparam int unsigned MAX_LOCK = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [1:0]    grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic ack0_seen, ack1_seen;
  int   w0, w1;

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    bus_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    reset = 1'b1;
    tick();

    // single m0 write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA5;
    settle();
    chk("single_pre_grant", grant, 2'b00);
    chk("single_pre_ack", m0_ack, 1'b0);
    tick();
    chk("single_grant", grant, 2'b01);
    chk("single_bus_we", bus_we, 1'b1);
    chk("single_bus_addr", bus_addr, 32'h10);
    chk("single_bus_wdata", bus_wdata, 32'hA5);
    chk("single_m0_ack", m0_ack, 1'b1);
    chk("single_m1_ack", m1_ack, 1'b0);
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    settle();
    chk("single_idle_grant", grant, 2'b00);
    chk("single_idle_we", bus_we, 1'b0);
    chk("single_idle_ack", m0_ack, 1'b0);
    tick();
    chk("single_idle2_grant", grant, 2'b00);

    // async reset in the middle of a granted write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h77;
    tick();
    chk("midrst_pre_grant", grant, 2'b01);
    chk("midrst_pre_we", bus_we, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_we", bus_we, 1'b0);
    chk("midrst_m0_ack", m0_ack, 1'b0);
    chk("midrst_addr", bus_addr, 32'h0);
    m0_req = 1'b0; m0_we = 1'b0;

    // tie from reset: m0, m1, m0, m1 with idle cycles between
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    tick();
    chk("tie_in_reset_grant", grant, 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("tie_grant_m0", grant, 2'b01);
        chk("tie_m0_ack", m0_ack, 1'b1);
        chk("tie_m1_ack", m1_ack, 1'b0);
        chk("tie_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("tie_m1_rdata", m1_rdata, 32'h0);
        chk("tie_addr_m0", bus_addr, 32'h100);
      end else begin
        chk("tie_grant_m1", grant, 2'b10);
        chk("tie_m1_ack", m1_ack, 1'b1);
        chk("tie_m0_ack", m0_ack, 1'b0);
        chk("tie_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("tie_m0_rdata", m0_rdata, 32'h0);
        chk("tie_addr_m1", bus_addr, 32'h200);
      end
      tick();
      chk("tie_idle_grant", grant, 2'b00);
      chk("tie_idle_acks", {m1_ack, m0_ack}, 2'b00);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("tie_done_grant", grant, 2'b00);

    // m1 locked burst of 12 reads with m0 waiting
    bus_rdata = 32'h1234_5678;
    m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
    tick();
    chk("lock_first_grant", grant, 2'b10);
    chk("lock_first_ack", m1_ack, 1'b1);
    chk("lock_first_rdata", m1_rdata, 32'h1234_5678);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("lock_burst_grant", grant, 2'b10);
      chk("lock_burst_m1_ack", m1_ack, 1'b1);
      chk("lock_burst_m0_ack", m0_ack, 1'b0);
    end
    tick();
    chk("lock_release_grant", grant, 2'b00);
    chk("lock_release_acks", {m1_ack, m0_ack}, 2'b00);
    tick();
    chk("lock_m0_turn_grant", grant, 2'b01);
    chk("lock_m0_turn_ack", m0_ack, 1'b1);
    chk("lock_m0_turn_rdata", m0_rdata, 32'h1234_5678);
    chk("lock_m0_turn_m1_rdata", m1_rdata, 32'h0);
    tick();
    m0_req = 1'b0;
    settle();
    chk("lock_gap_grant", grant, 2'b00);
    tick();
    chk("lock_resume_grant", grant, 2'b10);
    chk("lock_resume_ack", m1_ack, 1'b1);
    for (int k = 10; k <= 12; k++) begin
      tick();
      chk("lock_tail_grant", grant, 2'b10);
      chk("lock_tail_ack", m1_ack, 1'b1);
    end
    tick();
    m1_req = 1'b0; m1_lock = 1'b0;
    settle();
    chk("lock_drop_grant", grant, 2'b10);
    chk("lock_drop_ack", m1_ack, 1'b0);
    chk("lock_drop_we", bus_we, 1'b0);
    tick();
    chk("lock_drop_idle", grant, 2'b00);

    // m0 lock then request drops; m1 waiting
    m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h55;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    tick();
    chk("lkidle_grant", grant, 2'b01);
    chk("lkidle_ack", m0_ack, 1'b1);
    chk("lkidle_we", bus_we, 1'b1);
    chk("lkidle_wdata", bus_wdata, 32'h55);
    tick();
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
    settle();
    chk("lkidle_cont_grant", grant, 2'b01);
    chk("lkidle_cont_ack", m0_ack, 1'b0);
    chk("lkidle_cont_we", bus_we, 1'b0);
    chk("lkidle_cont_m1_ack", m1_ack, 1'b0);
    tick();
    chk("lkidle_idle", grant, 2'b00);
    tick();
    chk("lkidle_m1_grant", grant, 2'b10);
    chk("lkidle_m1_ack", m1_ack, 1'b1);
    tick();
    m1_req = 1'b0;
    settle();
    chk("lkidle_end", grant, 2'b00);

    // randomized traffic with invariant checks
    ack0_seen = 1'b0; ack1_seen = 1'b0; w0 = 0; w1 = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (!m0_req || ack0_seen) begin
        m0_req   = ($urandom_range(0, 2) != 0);
        m0_we    = 1'($urandom_range(0, 1));
        m0_lock  = 1'($urandom_range(0, 1));
        m0_addr  = $urandom;
        m0_wdata = $urandom;
      end
      if (!m1_req || ack1_seen) begin
        m1_req   = ($urandom_range(0, 2) != 0);
        m1_we    = 1'($urandom_range(0, 1));
        m1_lock  = 1'($urandom_range(0, 1));
        m1_addr  = $urandom;
        m1_wdata = $urandom;
      end
      bus_rdata = $urandom;
      settle();
      chk("rnd_grant_onehot", {63'b0, grant == 2'b11}, 64'd0);
      chk("rnd_single_ack", {63'b0, m0_ack & m1_ack}, 64'd0);
      chk("rnd_we_idle", {63'b0, bus_we & (grant == 2'b00)}, 64'd0);
      chk("rnd_m0_ack", m0_ack, grant[0] & m0_req);
      chk("rnd_m1_ack", m1_ack, grant[1] & m1_req);
      chk("rnd_m0_rdata", m0_rdata, grant[0] ? bus_rdata : 32'h0);
      chk("rnd_m1_rdata", m1_rdata, grant[1] ? bus_rdata : 32'h0);
      w0 = (m0_req && !m0_ack) ? w0 + 1 : 0;
      w1 = (m1_req && !m1_ack) ? w1 + 1 : 0;
      chk("rnd_wait_m0", (w0 > int'(MAX_LOCK + 2)) ? 64'(w0) : 64'd0, 64'd0);
      chk("rnd_wait_m1", (w1 > int'(MAX_LOCK + 2)) ? 64'(w1) : 64'd0, 64'd0);
      ack0_seen = m0_ack;
      ack1_seen = m1_ack;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
